// File: rtl/mem_access_stage_pkg.sv
// mips_pkg: definitions shared by the MEM stage.
//   M_MEMWRITE / M_MEMREAD / M_BRANCH : bit positions inside the M control field
//   mem_state_t                       : memory access FSM states
//   is_memop()                        : true when the M field requests a data-memory access
// No ports; imported by the stage top and the byte lane unit.
package mips_pkg;

    localparam int M_MEMWRITE = 0;
    localparam int M_MEMREAD  = 1;
    localparam int M_BRANCH   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_memop(input logic mem_write, input logic mem_read);
        return mem_write | mem_read;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory port of the MEM stage (req/ack handshake).
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_be    : byte enables
//   mem_ack   : access complete, mem_rdata valid in the same cycle
//   mem_rdata : read data
// master = pipeline stage, slave = memory.
interface mem_access_stage_if #(
    parameter int SIZE = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [SIZE-1:0] mem_addr;
    logic [SIZE-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_ack;
    logic [SIZE-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage_byte_lane.sv
// byte_lane_unit: combinational lane handling for word / byte accesses (little endian).
//   is_byte   in  : 1 = SB/LB, 0 = SW/LW
//   byte_off  in  : alu_in[1:0], byte position inside the word
//   wdata     in  : store data (rt)
//   rdata     in  : raw memory read data
//   be        out : byte enables
//   wdata_out out : store data, low byte replicated on every lane for SB
//   rdata_out out : load data, selected byte extended for LB
// Build option: MEM_BYTE_SIGNEXT_EN defined -> LB sign-extends, otherwise zero-extends.
module byte_lane_unit #(
    parameter int SIZE = 32
) (
    input  logic            is_byte,
    input  logic [1:0]      byte_off,
    input  logic [SIZE-1:0] wdata,
    input  logic [SIZE-1:0] rdata,
    output logic [3:0]      be,
    output logic [SIZE-1:0] wdata_out,
    output logic [SIZE-1:0] rdata_out
);
    logic [7:0] rbyte;

    always_comb begin
        be        = 4'b1111;
        wdata_out = wdata;
        rdata_out = rdata;
        rbyte     = rdata[8*byte_off +: 8];
        if (is_byte) begin
            be        = 4'b0001 << byte_off;
            wdata_out = {(SIZE/8){wdata[7:0]}};
`ifdef MEM_BYTE_SIGNEXT_EN
            rdata_out = {{(SIZE-8){rbyte[7]}}, rbyte};
`else
            rdata_out = {{(SIZE-8){1'b0}}, rbyte};
`endif
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS32 pipeline.
// Drives the data-memory port from the EX/MEM register, resolves branches and
// registers results into MEM/WB. stall is raised while an access is outstanding.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   WB_in, M_in         control from EX/MEM (M: [0]=MemWrite [1]=MemRead [2]=Branch)
//   zero_in, alu_in     ALU zero flag / ALU result (memory byte address)
//   wdata_in            store data
//   btarget_in          branch target
//   AWriteReg_in        destination register
//   is_byte_in          1 = byte access
//   mem_bus             data-memory port (master side)
//   stall               hold upstream pipeline
//   PCSrc, btarget_out  branch decision / target (combinational)
//   WB_out, rdata_out, alu_out, AWriteReg_out   MEM/WB register
// Build option: MEM_BYTE_SIGNEXT_EN (LB sign extension, see byte_lane_unit).
//
// state | meaning
// IDLE  | no access outstanding; a memop issues mem_req this cycle
// WAIT  | access issued, waiting for mem_ack; mem_* held stable
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int S_WB      = 2,
    parameter int S_M       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [S_WB-1:0]      WB_in,
    input  logic [S_M-1:0]       M_in,
    input  logic                 zero_in,
    input  logic [SIZE-1:0]      alu_in,
    input  logic [SIZE-1:0]      wdata_in,
    input  logic [SIZE-1:0]      btarget_in,
    input  logic [ADDR_SIZE-1:0] AWriteReg_in,
    input  logic                 is_byte_in,
    mem_access_stage_if.master   mem_bus,
    output logic                 stall,
    output logic                 PCSrc,
    output logic [SIZE-1:0]      btarget_out,
    output logic [S_WB-1:0]      WB_out,
    output logic [SIZE-1:0]      rdata_out,
    output logic [SIZE-1:0]      alu_out,
    output logic [ADDR_SIZE-1:0] AWriteReg_out
);
    mem_state_t      state, state_nxt;
    logic            memop;
    logic            req_c;
    logic            read_done;
    logic [SIZE-1:0] load_data;

    assign memop = is_memop(M_in[M_MEMWRITE], M_in[M_MEMREAD]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        case (state)
            IDLE: begin
                req_c = memop;
                if (memop && !mem_bus.mem_ack) state_nxt = WAIT;
            end
            WAIT: begin
                req_c = 1'b1;
                if (mem_bus.mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with rst_n drops the request the moment reset is applied,
    // not just at the next edge.
    assign mem_bus.mem_req  = req_c & rst_n;
    // Write wins when both MemWrite and MemRead are set.
    assign mem_bus.mem_we   = M_in[M_MEMWRITE];
    assign mem_bus.mem_addr = {alu_in[SIZE-1:2], 2'b00};

    byte_lane_unit #(.SIZE(SIZE)) u_lane (
        .is_byte   (is_byte_in),
        .byte_off  (alu_in[1:0]),
        .wdata     (wdata_in),
        .rdata     (mem_bus.mem_rdata),
        .be        (mem_bus.mem_be),
        .wdata_out (mem_bus.mem_wdata),
        .rdata_out (load_data)
    );

    assign stall     = mem_bus.mem_req & ~mem_bus.mem_ack;
    assign read_done = mem_bus.mem_req & mem_bus.mem_ack
                     & ~M_in[M_MEMWRITE] & M_in[M_MEMREAD];

    assign PCSrc       = M_in[M_BRANCH] & zero_in;
    assign btarget_out = btarget_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_out        <= '0;
            rdata_out     <= '0;
            alu_out       <= '0;
            AWriteReg_out <= '0;
        end else if (stall) begin
            // Bubble into WB so the stalled instruction retires only once.
            WB_out <= '0;
        end else begin
            WB_out        <= WB_in;
            alu_out       <= alu_in;
            AWriteReg_out <= AWriteReg_in;
            if (read_done) rdata_out <= load_data;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mips_pkg::*;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  WB_in = '0;
    logic [2:0]  M_in = '0;
    logic        zero_in = 1'b0;
    logic [31:0] alu_in = '0;
    logic [31:0] wdata_in = '0;
    logic [31:0] btarget_in = '0;
    logic [4:0]  AWriteReg_in = '0;
    logic        is_byte_in = 1'b0;
    logic        stall, PCSrc;
    logic [31:0] btarget_out, rdata_out, alu_out;
    logic [1:0]  WB_out;
    logic [4:0]  AWriteReg_out;

    int    n_vec  = 0;
    int    n_miss = 0;
    logic  mon_en = 1'b0;
    logic [31:0] rd_model = '0;
    exp_t  sb[$];

    mem_access_stage_if #(.SIZE(32)) mem_bus ();

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .WB_in         (WB_in),
        .M_in          (M_in),
        .zero_in       (zero_in),
        .alu_in        (alu_in),
        .wdata_in      (wdata_in),
        .btarget_in    (btarget_in),
        .AWriteReg_in  (AWriteReg_in),
        .is_byte_in    (is_byte_in),
        .mem_bus       (mem_bus),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .btarget_out   (btarget_out),
        .WB_out        (WB_out),
        .rdata_out     (rdata_out),
        .alu_out       (alu_out),
        .AWriteReg_out (AWriteReg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every edge that is not a stall retires one issued instruction.
    initial begin
        logic s, en;
        exp_t e;
        forever begin
            @(posedge clk);
            s  = stall;
            en = mon_en;
            #1;
            if (en) begin
                if (s) begin
                    chk("bubble_wb", 32'(WB_out), 32'h0);
                end else if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb_underflow: got retire expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("wb_out",    32'(WB_out),        32'(e.wb));
                    chk("alu_out",   alu_out,            e.alu);
                    chk("wreg_out",  32'(AWriteReg_out), 32'(e.wreg));
                    chk("rdata_out", rdata_out,          e.rdata);
                end
            end
        end
    end

    task automatic issue(input string tag, input logic [1:0] wb, input logic [2:0] m,
                         input logic zero, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [31:0] btarget, input logic [4:0] wreg, input logic is_byte,
                         input logic [31:0] rdata, input int ack_delay, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        logic memop;
        @(negedge clk);
        WB_in = wb; M_in = m; zero_in = zero; alu_in = alu; wdata_in = wdata;
        btarget_in = btarget; AWriteReg_in = wreg; is_byte_in = is_byte;
        mem_bus.mem_rdata = rdata;
        mem_bus.mem_ack = (ack_delay == 0);
        memop = m[0] | m[1];
        if (m[1] && !m[0]) rd_model = exp_rd;
        sb.push_back('{wb, alu, wreg, rd_model});
        mon_en = 1'b1;
        #1;
        chk({tag, "_req"},   32'(mem_bus.mem_req), 32'(memop));
        chk({tag, "_pcsrc"}, 32'(PCSrc), 32'(m[2] & zero));
        chk({tag, "_btgt"},  btarget_out, btarget);
        if (memop) begin
            chk({tag, "_addr"}, mem_bus.mem_addr, {alu[31:2], 2'b00});
            chk({tag, "_be"},   32'(mem_bus.mem_be), 32'(exp_be));
            chk({tag, "_we"},   32'(mem_bus.mem_we), 32'(m[0]));
            if (m[0]) chk({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
        end
        for (int i = 0; i < ack_delay; i++) begin
            chk({tag, "_stall"}, 32'(stall), 32'h1);
            @(posedge clk);
            @(negedge clk);
            if (i == ack_delay - 1) mem_bus.mem_ack = 1'b1;
            #1;
            chk({tag, "_req_hold"},  32'(mem_bus.mem_req), 32'h1);
            chk({tag, "_addr_hold"}, mem_bus.mem_addr, {alu[31:2], 2'b00});
        end
        chk({tag, "_nostall"}, 32'(stall), 32'h0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lb2, lb1;
`ifdef MEM_BYTE_SIGNEXT_EN
        lb2 = 32'hFFFFFF80;
        lb1 = 32'hFFFFFFFF;
`else
        lb2 = 32'h00000080;
        lb1 = 32'h000000FF;
`endif
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   32'(mem_bus.mem_req), 32'h0);
        chk("rst_alu",   alu_out, 32'h0);
        rst_n = 1'b1;

        // Reset while an access is outstanding.
        WB_in = 2'b11; M_in = 3'b000; alu_in = 32'h55; AWriteReg_in = 5'd7;
        @(posedge clk);
        #1 chk("pre_alu", alu_out, 32'h55);
        @(negedge clk);
        M_in = 3'b001; alu_in = 32'h104; wdata_in = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rw_stall", 32'(stall), 32'h1);
        chk("rw_state", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        #1;
        chk("rw_req_drop", 32'(mem_bus.mem_req), 32'h0);
        chk("rw_wb",       32'(WB_out), 32'h0);
        chk("rw_alu",      alu_out, 32'h0);
        chk("rw_wreg",     32'(AWriteReg_out), 32'h0);
        chk("rw_rdata",    rdata_out, 32'h0);
        @(negedge clk);
        M_in = 3'b000;
        rst_n = 1'b1;
        #1;
        chk("rw_idle", 32'(dut.state), 32'(IDLE));
        chk("rw_req0", 32'(mem_bus.mem_req), 32'h0);
        rd_model = '0;

        //     tag     wb     m       z     alu            wdata          btarget        wreg  byte  rdata          dly  exp_rd         be       wdata_exp
        issue("sw",    2'b01, 3'b001, 1'b0, 32'h00000104, 32'hDEADBEEF, 32'h0,        5'd3, 1'b0, 32'hBADBAD00, 3,   32'h0,        4'b1111, 32'hDEADBEEF);
        issue("sb",    2'b01, 3'b001, 1'b0, 32'h00000203, 32'h000000A5, 32'h0,        5'd4, 1'b1, 32'hBADBAD00, 1,   32'h0,        4'b1000, 32'hA5A5A5A5);
        issue("lb2",   2'b11, 3'b010, 1'b0, 32'h00000302, 32'h0,        32'h0,        5'd5, 1'b1, 32'h1280FF34, 2,   lb2,          4'b0100, 32'h0);
        issue("lw",    2'b11, 3'b010, 1'b0, 32'h00000010, 32'h0,        32'h0,        5'd6, 1'b0, 32'hCAFEF00D, 0,   32'hCAFEF00D, 4'b1111, 32'h0);
        issue("beq",   2'b00, 3'b100, 1'b1, 32'h00000000, 32'h0,        32'h00000040, 5'd0, 1'b0, 32'h0,        0,   32'h0,        4'b1111, 32'h0);
        issue("bne",   2'b00, 3'b100, 1'b0, 32'h00000001, 32'h0,        32'h00000080, 5'd0, 1'b0, 32'h0,        0,   32'h0,        4'b1111, 32'h0);
        issue("lb1",   2'b11, 3'b010, 1'b0, 32'h00000301, 32'h0,        32'h0,        5'd8, 1'b1, 32'h1280FF34, 0,   lb1,          4'b0010, 32'h0);
        issue("lb0",   2'b11, 3'b010, 1'b0, 32'h00000300, 32'h0,        32'h0,        5'd9, 1'b1, 32'h1280FF34, 1,   32'h00000034, 4'b0001, 32'h0);
        issue("both",  2'b01, 3'b011, 1'b0, 32'h00000008, 32'h11223344, 32'h0,        5'd1, 1'b0, 32'hBADBAD00, 1,   32'h0,        4'b1111, 32'h11223344);
        issue("alu",   2'b10, 3'b000, 1'b0, 32'h0000ABCD, 32'h0,        32'h0,        5'd31,1'b0, 32'hBADBAD00, 0,   32'h0,        4'b1111, 32'h0);

        @(negedge clk);
        mon_en = 1'b0;
        mem_bus.mem_ack = 1'b0;
        M_in = 3'b000;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
